// File: rtl/hamming74_decoder.sv
// Hamming(7,4) decoder with a 2-stage valid/ready pipeline and saturating error counters.
//
// Handshake: a word moves across an interface on a cycle where valid and ready are both
// high. The producer keeps valid and data stable until that happens. Here ready does not
// depend on valid. On the output side out_* hold while out_valid=1 and out_ready=0. On the
// input side in_ready = !out_valid | out_ready, because both stages advance together.
module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       in_codeword,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] data_err_count,
    output logic [CNT_W-1:0] par_err_count
);

    logic       en;
    logic       out_fire;
    logic [2:0] in_syndrome;
    logic       s1_valid;
    logic [6:0] s1_codeword;
    logic [2:0] s1_syndrome;
    logic [6:0] flip_mask;
    logic [6:0] fixed_cw;
    logic       data_hit;
    logic       par_hit;

    // Both stages move as one; a stall freezes the entire pipeline.
    assign en       = !out_valid || out_ready;
    // Hold off the producer while reset is asserted, even though the pipeline is empty.
    assign in_ready = en && reset;
    assign out_fire = out_valid && out_ready;

    // Syndrome bits {s1,s2,s3}. Each bit re-checks one parity group, including its parity bit.
    always_comb begin
        in_syndrome[2] = in_codeword[6] ^ in_codeword[4] ^ in_codeword[2] ^ in_codeword[0];
        in_syndrome[1] = in_codeword[5] ^ in_codeword[4] ^ in_codeword[1] ^ in_codeword[0];
        in_syndrome[0] = in_codeword[3] ^ in_codeword[2] ^ in_codeword[1] ^ in_codeword[0];
    end

    // Stage 1: capture the raw codeword and its syndrome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_codeword <= '0;
            s1_syndrome <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_codeword <= in_codeword;
                s1_syndrome <= in_syndrome;
            end
        end
    end

    // Map a syndrome to the single codeword bit it points at.
    always_comb begin
        flip_mask = 7'b0000000;
        case (s1_syndrome)
            3'd4:    flip_mask = 7'b1000000;  // p1
            3'd2:    flip_mask = 7'b0100000;  // p2
            3'd6:    flip_mask = 7'b0010000;  // d3
            3'd1:    flip_mask = 7'b0001000;  // p3
            3'd5:    flip_mask = 7'b0000100;  // d2
            3'd3:    flip_mask = 7'b0000010;  // d1
            3'd7:    flip_mask = 7'b0000001;  // d0
            default: flip_mask = 7'b0000000;
        endcase
    end

    assign fixed_cw = s1_codeword ^ flip_mask;

    // Stage 2: register the corrected data word and its error status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_syndrome <= '0;
            out_err      <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= {fixed_cw[4], fixed_cw[2], fixed_cw[1], fixed_cw[0]};
                out_syndrome <= s1_syndrome;
                out_err      <= (s1_syndrome != 3'd0);
            end
        end
    end

    // Classify the delivered word by which kind of bit its correction touched.
    always_comb begin
        data_hit = 1'b0;
        par_hit  = 1'b0;
        case (out_syndrome)
            3'd3, 3'd5, 3'd6, 3'd7: data_hit = out_fire;
            3'd1, 3'd2, 3'd4:       par_hit  = out_fire;
            default: begin
                data_hit = 1'b0;
                par_hit  = 1'b0;
            end
        endcase
    end

    // Saturating statistics. A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_err_count <= '0;
            par_err_count  <= '0;
        end else if (clr_counts) begin
            data_err_count <= '0;
            par_err_count  <= '0;
        end else begin
            if (data_hit && (data_err_count != '1)) begin
                data_err_count <= data_err_count + 1'b1;
            end
            if (par_hit && (par_err_count != '1)) begin
                par_err_count <= par_err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
// Directed bench for hamming74_decoder. A default-width instance and a CNT_W=2 instance
// share every input, so the narrow counters can be pushed into saturation.
module tb_hamming74_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] in_codeword;
    logic       in_valid;
    logic       out_ready;
    logic       clr_counts;

    logic        in_ready,  in_ready2;
    logic [3:0]  out_data,  out_data2;
    logic [2:0]  out_syndrome, out_syndrome2;
    logic        out_err,   out_err2;
    logic        out_valid, out_valid2;
    logic [15:0] data_err_count, par_err_count;
    logic [1:0]  data_err_count2, par_err_count2;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {kind[1:0], data[3:0], syndrome[2:0], err}; kind 0=clean 1=data 2=parity
    logic [9:0]  exp_q[$];
    logic [9:0]  drv_exp;
    int unsigned m_data, m_par, m_data2, m_par2;
    bit          stalled;
    bit          accepted;
    logic [7:0]  held;

    hamming74_decoder dut (
        .clk(clk), .reset(rst_n), .in_codeword(in_codeword), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_syndrome(out_syndrome),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .clr_counts(clr_counts), .data_err_count(data_err_count), .par_err_count(par_err_count)
    );

    hamming74_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(rst_n), .in_codeword(in_codeword), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_syndrome(out_syndrome2),
        .out_err(out_err2), .out_valid(out_valid2), .out_ready(out_ready),
        .clr_counts(clr_counts), .data_err_count(data_err_count2), .par_err_count(par_err_count2)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encoder convention: {p1,p2,d3,p3,d2,d1,d0}
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3]^d[2]^d[0], d[3]^d[1]^d[0], d[3], d[2]^d[1]^d[0], d[2], d[1], d[0]};
    endfunction

    // Syndrome expected when codeword bit i is flipped
    function automatic logic [2:0] flip_syn(input int i);
        case (i)
            6: return 3'd4;
            5: return 3'd2;
            4: return 3'd6;
            3: return 3'd1;
            2: return 3'd5;
            1: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Driver tasks
    task automatic drive(input logic [6:0] cw, input logic [9:0] e);
        in_codeword = cw;
        in_valid    = 1'b1;
        drv_exp     = e;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: check at the negedge, update the scoreboard, return 1 time unit after the posedge
    task automatic cycle();
        logic [9:0] e;
        logic [7:0] got;
        @(negedge clk);
        got = {out_data, out_syndrome, out_err};
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        check("data_err_count", 32'(data_err_count), m_data);
        check("par_err_count", 32'(par_err_count), m_par);
        check("data_err_count_w2", 32'(data_err_count2), m_data2);
        check("par_err_count_w2", 32'(par_err_count2), m_par2);
        if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_hold", 32'(got), 32'(held));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 'x;
            check("out_word", 32'(got), 32'(e[7:0]));
            if (e[9:8] == 2'd1) begin
                m_data++;
                if (m_data2 < 3) m_data2++;
            end else if (e[9:8] == 2'd2) begin
                m_par++;
                if (m_par2 < 3) m_par2++;
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(drv_exp);
        if (clr_counts) begin
            m_data = 0; m_par = 0; m_data2 = 0; m_par2 = 0;
        end
        stalled = out_valid && !out_ready;
        held    = got;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] flip;
        logic [1:0] kind;
        logic [9:0] e;
        int         i;

        // Reset
        rst_n = 1'b0; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b0; clr_counts = 1'b0;
        drv_exp = '0; m_data = 0; m_par = 0; m_data2 = 0; m_par2 = 0; stalled = 0; held = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_syndrome", 32'(out_syndrome), 32'(0));
        check("rst_out_err", 32'(out_err), 32'(0));
        check("rst_data_cnt", 32'(data_err_count), 32'(0));
        check("rst_par_cnt", 32'(par_err_count), 32'(0));
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Clean word, 2-cycle latency
        drive(7'b0110011, {2'd0, 4'b1011, 3'd0, 1'b0});
        cycle();
        idle();
        check("clean_lat1_valid", 32'(out_valid), 32'(0));
        cycle();
        check("clean_lat2_valid", 32'(out_valid), 32'(1));
        check("clean_data", 32'(out_data), 32'(4'b1011));
        check("clean_syndrome", 32'(out_syndrome), 32'(0));
        check("clean_err", 32'(out_err), 32'(0));
        cycle();
        cycle();

        // Data-bit error (cw[2] flipped)
        drive(7'b0110111, {2'd1, 4'b1011, 3'b101, 1'b1});
        cycle();
        idle();
        cycle();
        check("derr_data", 32'(out_data), 32'(4'b1011));
        check("derr_syndrome", 32'(out_syndrome), 32'(3'b101));
        check("derr_err", 32'(out_err), 32'(1));
        cycle();
        check("derr_count", 32'(data_err_count), 32'(1));

        // Parity-bit error (cw[6] flipped)
        drive(7'b1110011, {2'd2, 4'b1011, 3'b100, 1'b1});
        cycle();
        idle();
        cycle();
        check("perr_data", 32'(out_data), 32'(4'b1011));
        check("perr_syndrome", 32'(out_syndrome), 32'(3'b100));
        cycle();
        check("perr_par_count", 32'(par_err_count), 32'(1));
        check("perr_data_count", 32'(data_err_count), 32'(1));

        // Stream: 16 clean words then 7 single-bit flips of 7'b0110011 under random backpressure
        for (int d = 0; d < 23; d++) begin
            if (d < 16) begin
                drive(enc(4'(d)), {2'd0, 4'(d), 3'd0, 1'b0});
            end else begin
                i    = d - 16;
                flip = 7'b0000001 << i;
                kind = (i == 6 || i == 5 || i == 3) ? 2'd2 : 2'd1;
                e    = {kind, 4'b1011, flip_syn(i), 1'b1};
                drive(7'b0110011 ^ flip, e);
            end
            accepted = 0;
            for (int t = 0; t < 50 && !accepted; t++) begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
            end
            check("stream_accept", 32'(accepted), 32'(1));
        end
        idle();
        for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        cycle();
        check("stream_drained", 32'(exp_q.size()), 32'(0));
        check("stream_idle_valid", 32'(out_valid), 32'(0));
        check("total_data_count", 32'(data_err_count), 32'(5));
        check("total_par_count", 32'(par_err_count), 32'(4));
        check("sat_data_count_w2", 32'(data_err_count2), 32'(3));
        check("sat_par_count_w2", 32'(par_err_count2), 32'(3));

        // Clear in the same cycle as an error handshake
        drive(7'b0110111, {2'd1, 4'b1011, 3'b101, 1'b1});
        cycle();
        idle();
        cycle();
        check("clr_pre_valid", 32'(out_valid), 32'(1));
        clr_counts = 1'b1;
        cycle();
        clr_counts = 1'b0;
        check("clr_data_count", 32'(data_err_count), 32'(0));
        check("clr_par_count", 32'(par_err_count), 32'(0));
        check("clr_data_count_w2", 32'(data_err_count2), 32'(0));
        cycle();

        // Load a parity error so reset has a count to clear
        drive(7'b1110011, {2'd2, 4'b1011, 3'b100, 1'b1});
        cycle();
        idle();
        cycle();
        cycle();
        check("pre_rst_par_count", 32'(par_err_count), 32'(1));

        // Fill both stages under a stall, then reset asynchronously
        out_ready = 1'b0;
        drive(enc(4'b0101), {2'd0, 4'b0101, 3'd0, 1'b0});
        cycle();
        drive(enc(4'b1100), {2'd0, 4'b1100, 3'd0, 1'b0});
        cycle();
        idle();
        check("full_out_valid", 32'(out_valid), 32'(1));
        check("full_in_ready", 32'(in_ready), 32'(0));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_par_count", 32'(par_err_count), 32'(0));
        check("arst_data_count", 32'(data_err_count), 32'(0));
        check("arst_out_data", 32'(out_data), 32'(0));
        exp_q.delete();
        m_data = 0; m_par = 0; m_data2 = 0; m_par2 = 0; stalled = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // First word after reset release
        drive(7'b1100110, {2'd0, 4'b0110, 3'd0, 1'b0});
        cycle();
        idle();
        check("post_rst_lat1_valid", 32'(out_valid), 32'(0));
        cycle();
        check("post_rst_lat2_valid", 32'(out_valid), 32'(1));
        check("post_rst_data", 32'(out_data), 32'(4'b0110));
        cycle();
        cycle();
        check("post_rst_drained", 32'(out_valid), 32'(0));
        check("post_rst_queue", 32'(exp_q.size()), 32'(0));

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
